// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage that drives the register-file write port.
//
// Accepts one retiring instruction per in_valid/in_ready handshake. Non-load
// results (ALU, PC+4, immediate) are written in the next cycle. Loads wait in
// WAIT_MEM for a one-cycle mem_rvalid pulse. The returned word is then aligned
// and sign/zero-extended according to funct3.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - instruction handshake (in_ready is combinational)
//   in_regw, in_rd        - write enable and destination register
//   in_wbsel              - 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
//   in_funct3             - load size/sign
//   in_alu, in_pcp4, in_imm - result candidates (in_alu is the load address)
//   mem_rvalid, mem_rdata - load response (pulse) and aligned memory word
//   RegW, A3, Result      - registered register-file write port
//   busy, busy_rd         - load pending and its rd, for decode hazard stalls
//   err_align, err_funct3, err_timeout - sticky error flags, cleared by reset

module writeback_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regw,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wbsel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pcp4,
    input  logic [31:0] in_imm,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        RegW,
    output logic [4:0]  A3,
    output logic [31:0] Result,
    output logic        busy,
    output logic [4:0]  busy_rd,
    output logic        err_align,
    output logic        err_funct3,
    output logic        err_timeout
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [0:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    ld_rd_q;
    logic          ld_regw_q;
    logic [2:0]    ld_f3_q;
    logic [1:0]    ld_off_q;
    logic          ld_bad_q;

    logic          regw_q;
    logic [4:0]    a3_q;
    logic [31:0]   result_q;
    logic          busy_q;
    logic [4:0]    busy_rd_q;
    logic          err_align_q;
    logic          err_funct3_q;
    logic          err_timeout_q;

    logic          accept;
    logic          f3_bad;
    logic          misalign;
    logic [31:0]   sel_result;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_value;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Load validity, evaluated on the incoming instruction at accept time.
    always_comb begin
        f3_bad   = 1'b0;
        misalign = 1'b0;
        unique case (in_funct3)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = in_alu[0];
            3'b010:         misalign = (in_alu[1:0] != 2'b00);
            default:        f3_bad   = 1'b1;
        endcase
    end

    always_comb begin
        sel_result = in_alu;
        unique case (in_wbsel)
            2'b10:   sel_result = in_pcp4;
            2'b11:   sel_result = in_imm;
            default: sel_result = in_alu;
        endcase
    end

    // Align and extend the returned word using the latched offset/funct3.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (ld_off_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (ld_f3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'b0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'b0, ld_half};
            default: ld_value = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ld_rd_q       <= '0;
            ld_regw_q     <= 1'b0;
            ld_f3_q       <= '0;
            ld_off_q      <= '0;
            ld_bad_q      <= 1'b0;
            regw_q        <= 1'b0;
            a3_q          <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            busy_rd_q     <= '0;
            err_align_q   <= 1'b0;
            err_funct3_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            regw_q <= 1'b0;  // write enable is a one-cycle pulse
            unique case (state_q)
                IDLE: begin
                    // mem_rvalid is ignored here by construction.
                    if (accept) begin
                        if (in_wbsel != 2'b01) begin
                            regw_q   <= in_regw && (in_rd != 5'd0);
                            a3_q     <= in_rd;
                            result_q <= sel_result;
                        end else begin
                            ld_rd_q      <= in_rd;
                            ld_regw_q    <= in_regw;
                            ld_f3_q      <= in_funct3;
                            ld_off_q     <= in_alu[1:0];
                            ld_bad_q     <= f3_bad || misalign;
                            err_funct3_q <= err_funct3_q || f3_bad;
                            err_align_q  <= err_align_q || misalign;
                            cnt_q        <= '0;
                            busy_q       <= 1'b1;
                            busy_rd_q    <= in_rd;
                            state_q      <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response in the expiry cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        regw_q    <= ld_regw_q && (ld_rd_q != 5'd0) && !ld_bad_q;
                        a3_q      <= ld_rd_q;
                        result_q  <= ld_value;
                        busy_q    <= 1'b0;
                        busy_rd_q <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        busy_rd_q     <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RegW        = regw_q;
    assign A3          = a3_q;
    assign Result      = result_q;
    assign busy        = busy_q;
    assign busy_rd     = busy_rd_q;
    assign err_align   = err_align_q;
    assign err_funct3  = err_funct3_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_regw;
    logic [4:0]  in_rd;
    logic [1:0]  in_wbsel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu;
    logic [31:0] in_pcp4;
    logic [31:0] in_imm;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegW;
    logic [4:0]  A3;
    logic [31:0] Result;
    logic        busy;
    logic [4:0]  busy_rd;
    logic        err_align;
    logic        err_funct3;
    logic        err_timeout;

    writeback_unit #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regw(in_regw), .in_rd(in_rd), .in_wbsel(in_wbsel), .in_funct3(in_funct3),
        .in_alu(in_alu), .in_pcp4(in_pcp4), .in_imm(in_imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .RegW(RegW), .A3(A3), .Result(Result),
        .busy(busy), .busy_rd(busy_rd),
        .err_align(err_align), .err_funct3(err_funct3), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] res;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (RegW === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_a3", 32'(A3), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_a3", 32'(A3), 32'(w.a3));
                check("write_result", Result, w.res);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a3, input logic [31:0] res);
        wr_t w;
        w.a3  = a3;
        w.res = res;
        exp_q.push_back(w);
    endtask

    // Presents one instruction for a single cycle; returns #1 after the accept edge.
    task automatic issue(input logic regw, input logic [4:0] rd, input logic [1:0] wbsel,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pcp4, input logic [31:0] imm);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_regw   = regw;
        in_rd     = rd;
        in_wbsel  = wbsel;
        in_funct3 = f3;
        in_alu    = alu;
        in_pcp4   = pcp4;
        in_imm    = imm;
        tick();
        in_valid = 1'b0;
    endtask

    // Load whose response arrives 'delay' cycles after the accept cycle.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input int delay, input logic [31:0] rdata,
                           input logic wr, input logic [31:0] exp_val);
        if (wr) expect_wr(rd, exp_val);
        issue(1'b1, rd, 2'b01, f3, addr, 32'h0, 32'h0);
        for (int i = 1; i < delay; i++) begin
            check("busy_wait", 32'(busy), 32'd1);
            check("busy_rd_wait", 32'(busy_rd), 32'(rd));
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        check("busy_after_resp", 32'(busy), 32'd0);
        check("regw_after_resp", 32'(RegW), 32'(wr));
        check("ready_after_resp", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_regw = 1'b0; in_rd = '0; in_wbsel = '0;
        in_funct3 = '0; in_alu = '0; in_pcp4 = '0; in_imm = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("ready_in_reset", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("reset_regw", 32'(RegW), 32'd0);
        check("reset_a3", 32'(A3), 32'd0);
        check("reset_result", Result, 32'd0);
        check("reset_busy", {27'b0, busy_rd}, 32'd0);
        check("reset_errs", {29'b0, err_align, err_funct3, err_timeout}, 32'd0);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // ALU then back-to-back JAL
        expect_wr(5'd5, 32'h0000_1234);
        issue(1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
        check("alu_regw_n1", 32'(RegW), 32'd1);
        expect_wr(5'd1, 32'h0000_0104);
        issue(1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0000_0104, 32'h0);
        check("jal_regw_n2", 32'(RegW), 32'd1);
        tick();
        check("regw_drops", 32'(RegW), 32'd0);
        // LUI
        expect_wr(5'd3, 32'hABCD_E000);
        issue(1'b1, 5'd3, 2'b11, 3'b000, 32'h1, 32'h2, 32'hABCD_E000);
        tick();

        // Byte / halfword / word loads
        do_load(5'd7, 3'b000, 32'h0000_1003, 3, 32'h80FF_FF7F, 1'b1, 32'hFFFF_FF80);
        do_load(5'd7, 3'b100, 32'h0000_1003, 3, 32'h80FF_FF7F, 1'b1, 32'h0000_0080);
        do_load(5'd6, 3'b000, 32'h0000_1000, 1, 32'h80FF_FF7F, 1'b1, 32'h0000_007F);
        do_load(5'd8, 3'b001, 32'h0000_2002, 2, 32'h8001_0000, 1'b1, 32'hFFFF_8001);
        do_load(5'd8, 3'b101, 32'h0000_2002, 2, 32'h8001_0000, 1'b1, 32'h0000_8001);
        do_load(5'd4, 3'b001, 32'h0000_2000, 2, 32'h8001_F00F, 1'b1, 32'hFFFF_F00F);
        do_load(5'd9, 3'b010, 32'h0000_2000, 2, 32'h1234_5678, 1'b1, 32'h1234_5678);
        check("no_err_yet", {29'b0, err_align, err_funct3, err_timeout}, 32'd0);

        // Response in the last honoured cycle (accept+TIMEOUT) wins
        do_load(5'd10, 3'b010, 32'h0000_3000, 8, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
        check("boundary_no_timeout", 32'(err_timeout), 32'd0);

        // Misaligned LW: flagged, response awaited, no write
        do_load(5'd9, 3'b010, 32'h0000_2001, 2, 32'h1111_2222, 1'b0, 32'h0);
        check("err_align_set", 32'(err_align), 32'd1);
        // Illegal funct3
        do_load(5'd9, 3'b011, 32'h0000_2000, 2, 32'h1111_2222, 1'b0, 32'h0);
        check("err_funct3_set", 32'(err_funct3), 32'd1);

        // Timeout with no response
        issue(1'b1, 5'd12, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("to_not_yet", 32'(err_timeout), 32'd0);
        check("to_busy_last", 32'(busy), 32'd1);
        tick();
        check("to_set", 32'(err_timeout), 32'd1);
        check("to_ready", 32'(in_ready), 32'd1);
        check("to_busy_clear", 32'(busy), 32'd0);
        check("to_no_write", 32'(RegW), 32'd0);

        // rd=0 never writes; stray mem_rvalid in IDLE ignored
        issue(1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_5555, 32'h0, 32'h0);
        check("rd0_no_regw", 32'(RegW), 32'd0);
        check("rd0_result_updates", Result, 32'h0000_5555);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("idle_rvalid_no_regw", 32'(RegW), 32'd0);
        tick();

        // Reset two cycles into WAIT_MEM
        issue(1'b1, 5'd11, 2'b01, 3'b000, 32'h0000_4000, 32'h0, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00AA;
        tick();
        mem_rvalid = 1'b0;
        check("rst_wait_no_regw", 32'(RegW), 32'd0);
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_busy_rd", 32'(busy_rd), 32'd0);
        check("rst_wait_errs", {29'b0, err_align, err_funct3, err_timeout}, 32'd0);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
